// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port video RAM between the LCD fetcher,
// the DMA engine and direct CPU accesses. One access is granted per ce slot
// with fixed priority LCD > DMA > CPU. A CPU that has lost CPU_WAIT_MAX
// consecutive slots is promoted above DMA, but never above LCD.
module vram_arbiter #(
  parameter int AW           = 13,
  parameter int CPU_WAIT_MAX = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic          lcd_en,
  input  logic          lcd_req,
  input  logic [AW-1:0] lcd_addr,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_wdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  input  logic [7:0]    vram_rdata,
  output logic [AW-1:0] vram_addr,
  output logic          vram_we,
  output logic [7:0]    vram_wdata,
  output logic          lcd_gnt,
  output logic          dma_gnt,
  output logic          cpu_gnt,
  output logic          lcd_rvalid,
  output logic          dma_rvalid,
  output logic          cpu_rvalid,
  output logic [7:0]    rdata,
  output logic          cpu_wait
);

  // Read tag: which requester owns the read currently in flight.
  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_LCD  = 2'd1;
  localparam logic [1:0] TAG_DMA  = 2'd2;
  localparam logic [1:0] TAG_CPU  = 2'd3;

  localparam logic [3:0] WAIT_MAX = 4'(CPU_WAIT_MAX);

  logic [3:0]    starve_cnt;
  logic [1:0]    rd_tag;

  logic          lcd_win;
  logic          dma_win;
  logic          cpu_win;
  logic          any_win;
  logic [AW-1:0] win_addr;
  logic          win_we;
  logic [7:0]    win_wdata;
  logic [1:0]    win_tag;

  // Pick this slot's winner and the bus values it will drive.
  always_comb begin
    lcd_win   = 1'b0;
    dma_win   = 1'b0;
    cpu_win   = 1'b0;
    win_addr  = vram_addr;
    win_we    = 1'b0;
    win_wdata = vram_wdata;
    win_tag   = TAG_NONE;
    if (lcd_req && lcd_en) begin
      lcd_win  = 1'b1;
      win_addr = lcd_addr;
      win_tag  = TAG_LCD;
    end else if (cpu_req && (starve_cnt >= WAIT_MAX)) begin
      cpu_win   = 1'b1;
      win_addr  = cpu_addr;
      win_we    = cpu_we;
      win_wdata = cpu_wdata;
      win_tag   = cpu_we ? TAG_NONE : TAG_CPU;
    end else if (dma_req) begin
      dma_win   = 1'b1;
      win_addr  = dma_addr;
      win_we    = dma_we;
      win_wdata = dma_wdata;
      win_tag   = dma_we ? TAG_NONE : TAG_DMA;
    end else if (cpu_req) begin
      cpu_win   = 1'b1;
      win_addr  = cpu_addr;
      win_we    = cpu_we;
      win_wdata = cpu_wdata;
      win_tag   = cpu_we ? TAG_NONE : TAG_CPU;
    end
    any_win = lcd_win | dma_win | cpu_win;
  end

  // Register the VRAM bus; an idle slot only drops the write strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vram_addr  <= '0;
      vram_we    <= 1'b0;
      vram_wdata <= '0;
    end else if (ce) begin
      if (any_win) begin
        vram_addr  <= win_addr;
        vram_we    <= win_we;
        vram_wdata <= win_wdata;
      end else begin
        vram_we <= 1'b0;
      end
    end
  end

  // One-slot grant pulses and the CPU stall flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lcd_gnt  <= 1'b0;
      dma_gnt  <= 1'b0;
      cpu_gnt  <= 1'b0;
      cpu_wait <= 1'b0;
    end else if (ce) begin
      lcd_gnt  <= lcd_win;
      dma_gnt  <= dma_win;
      cpu_gnt  <= cpu_win;
      cpu_wait <= cpu_req & ~cpu_win;
    end
  end

  // Read return pipeline: tag at grant, data and rvalid one slot later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_tag     <= TAG_NONE;
      lcd_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      rdata      <= '0;
    end else if (ce) begin
      rd_tag     <= win_tag;
      lcd_rvalid <= (rd_tag == TAG_LCD);
      dma_rvalid <= (rd_tag == TAG_DMA);
      cpu_rvalid <= (rd_tag == TAG_CPU);
      if (rd_tag != TAG_NONE) begin
        rdata <= vram_rdata;
      end
    end
  end

  // Count consecutive lost CPU slots, saturating so a long LCD run cannot wrap it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (ce) begin
      if (cpu_req && !cpu_win) begin
        if (starve_cnt != 4'hF) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: per-slot expectations go into a scoreboard
// queue as stimulus is driven and are popped after each clock edge.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        lcd_en, lcd_req;
  logic [12:0] lcd_addr;
  logic        dma_req, dma_we;
  logic [12:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        cpu_req, cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  vram_rdata;
  logic [12:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic        lcd_gnt, dma_gnt, cpu_gnt;
  logic        lcd_rvalid, dma_rvalid, cpu_rvalid;
  logic [7:0]  rdata;
  logic        cpu_wait;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  gnt;
    logic [2:0]  rv;
    logic [7:0]  rdata;
    logic        cw;
    logic [12:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } exp_t;

  exp_t sb[$];

  vram_arbiter #(.AW(13), .CPU_WAIT_MAX(3)) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .lcd_en(lcd_en), .lcd_req(lcd_req), .lcd_addr(lcd_addr),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .vram_rdata(vram_rdata),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
    .lcd_gnt(lcd_gnt), .dma_gnt(dma_gnt), .cpu_gnt(cpu_gnt),
    .lcd_rvalid(lcd_rvalid), .dma_rvalid(dma_rvalid), .cpu_rvalid(cpu_rvalid),
    .rdata(rdata), .cpu_wait(cpu_wait)
  );

  always #5 clk = ~clk;

  // VRAM contents as a fixed pattern; 0x0123 holds 0x5A.
  function automatic logic [7:0] pat(input logic [12:0] a);
    return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h78;
  endfunction

  assign vram_rdata = pat(vram_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] g, input logic [2:0] rv, input logic [7:0] rd,
                      input logic cw, input logic [12:0] a, input logic we, input logic [7:0] wd);
    exp_t e;
    e.gnt = g; e.rv = rv; e.rdata = rd; e.cw = cw; e.addr = a; e.we = we; e.wdata = wd;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("gnt", {29'd0, lcd_gnt, dma_gnt, cpu_gnt}, {29'd0, e.gnt});
      chk("rvalid", {29'd0, lcd_rvalid, dma_rvalid, cpu_rvalid}, {29'd0, e.rv});
      chk("cpu_wait", {31'd0, cpu_wait}, {31'd0, e.cw});
      chk("vram_addr", {19'd0, vram_addr}, {19'd0, e.addr});
      chk("vram_we", {31'd0, vram_we}, {31'd0, e.we});
      if (e.rv != 3'b000) chk("rdata", {24'd0, rdata}, {24'd0, e.rdata});
      if (e.we) chk("vram_wdata", {24'd0, vram_wdata}, {24'd0, e.wdata});
    end
  endtask

  task automatic drop_all();
    lcd_req = 1'b0; dma_req = 1'b0; cpu_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1;
    lcd_en = 1'b1; lcd_req = 1'b0; lcd_addr = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", {19'd0, vram_addr}, 32'd0);
    chk("rst_gnt", {29'd0, lcd_gnt, dma_gnt, cpu_gnt}, 32'd0);
    chk("rst_rvalid", {29'd0, lcd_rvalid, dma_rvalid, cpu_rvalid}, 32'd0);
    chk("rst_wait", {31'd0, cpu_wait}, 32'd0);
    reset = 1'b0;

    // CPU read of 0x0123
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123;
    push(3'b001, 3'b000, 8'h00, 1'b0, 13'h0123, 1'b0, 8'h00); step();
    drop_all();
    push(3'b000, 3'b001, 8'h5A, 1'b0, 13'h0123, 1'b0, 8'h00); step();

    // All three requesting: LCD wins; with LCD disabled, DMA wins
    lcd_req = 1'b1; lcd_addr = 13'h00AA;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 13'h00BB;
    cpu_req = 1'b1; cpu_addr = 13'h00CC;
    push(3'b100, 3'b000, 8'h00, 1'b1, 13'h00AA, 1'b0, 8'h00); step();
    drop_all();
    push(3'b000, 3'b100, pat(13'h00AA), 1'b0, 13'h00AA, 1'b0, 8'h00); step();
    lcd_en = 1'b0; lcd_req = 1'b1; dma_req = 1'b1; cpu_req = 1'b1;
    push(3'b010, 3'b000, 8'h00, 1'b1, 13'h00BB, 1'b0, 8'h00); step();
    drop_all(); lcd_en = 1'b1;
    push(3'b000, 3'b010, pat(13'h00BB), 1'b0, 13'h00BB, 1'b0, 8'h00); step();

    // DMA write stream vs CPU read: CPU wins after 3 lost slots
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 13'h0400; dma_wdata = 8'hC3;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
    for (int i = 0; i < 3; i++) begin
      push(3'b010, 3'b000, 8'h00, 1'b1, 13'h0400, 1'b1, 8'hC3); step();
    end
    chk("starve_3", {28'd0, dut.starve_cnt}, 32'd3);
    push(3'b001, 3'b000, 8'h00, 1'b0, 13'h0010, 1'b0, 8'h00); step();
    chk("starve_clr", {28'd0, dut.starve_cnt}, 32'd0);
    drop_all(); dma_we = 1'b0;
    push(3'b000, 3'b001, pat(13'h0010), 1'b0, 13'h0010, 1'b0, 8'h00); step();

    // Continuous LCD with CPU pending: CPU starves, counter saturates
    lcd_req = 1'b1; lcd_addr = 13'h0800;
    cpu_req = 1'b1; cpu_addr = 13'h0020;
    for (int i = 0; i < 20; i++) begin
      push(3'b100, (i == 0) ? 3'b000 : 3'b100, pat(13'h0800), 1'b1, 13'h0800, 1'b0, 8'h00);
      step();
    end
    chk("starve_sat", {28'd0, dut.starve_cnt}, 32'd15);
    // LCD disabled with req still high: CPU wins, in-flight LCD read returns
    lcd_en = 1'b0;
    push(3'b001, 3'b100, pat(13'h0800), 1'b0, 13'h0020, 1'b0, 8'h00); step();
    drop_all(); lcd_en = 1'b1;
    push(3'b000, 3'b001, pat(13'h0020), 1'b0, 13'h0020, 1'b0, 8'h00); step();

    // Alternating DMA 0x1FFF / CPU 0x0000 reads on consecutive slots
    for (int k = 0; k < 2; k++) begin
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 13'h1FFF;
      push(3'b010, (k == 0) ? 3'b000 : 3'b001, pat(13'h0000), 1'b0, 13'h1FFF, 1'b0, 8'h00); step();
      dma_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0000;
      push(3'b001, 3'b010, pat(13'h1FFF), 1'b0, 13'h0000, 1'b0, 8'h00); step();
      cpu_req = 1'b0;
    end
    push(3'b000, 3'b001, pat(13'h0000), 1'b0, 13'h0000, 1'b0, 8'h00); step();

    // ce=0 holds grant level across idle clocks
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0055;
    push(3'b001, 3'b000, 8'h00, 1'b0, 13'h0055, 1'b0, 8'h00); step();
    ce = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push(3'b001, 3'b000, 8'h00, 1'b0, 13'h0055, 1'b0, 8'h00); step();
    end
    ce = 1'b1; cpu_req = 1'b0;
    push(3'b000, 3'b001, pat(13'h0055), 1'b0, 13'h0055, 1'b0, 8'h00); step();

    // Reset one cycle after a DMA read grant discards the pending read
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 13'h0333;
    push(3'b010, 3'b000, 8'h00, 1'b0, 13'h0333, 1'b0, 8'h00); step();
    dma_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_addr", {19'd0, vram_addr}, 32'd0);
    chk("mid_rst_gnt", {29'd0, lcd_gnt, dma_gnt, cpu_gnt}, 32'd0);
    chk("mid_rst_rdata", {24'd0, rdata}, 32'd0);
    chk("mid_rst_tag", {30'd0, dut.rd_tag}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(3'b000, 3'b000, 8'h00, 1'b0, 13'h0000, 1'b0, 8'h00); step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
